axi_lite_rr_arbiter: RTL

- Round-robin arbiter sharing one AXI4-Lite register-file slave port among NM AXI4-Lite requesters, e.g. a CPU port plus an on-chip sequencer.
- Serialises transactions, with one read or write outstanding in total.
- Decodes each request against the register-file window. Out-of-window accesses are answered locally with DECERR.
- Sits between the masters and the register-file slave, all in the one AXI clock domain.

---
 rtl/axi_lite_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one AXI4-Lite register-file slave among NM requesters;
//          one transaction outstanding in total, out-of-window accesses answered locally with DECERR.
// Latency: grant cycle, then master-side valids from the next cycle; one IDLE cycle between transactions.
// Backpressure: requester readies pulse only on grant; master valids hold until handshake;
//               the response path is combinational (m_bready/m_rready follow the granted requester).
// Ports: s_* = NM packed requester AXI4-Lite ports (requester i at slice i),
//        m_* = single register-file AXI4-Lite master port (M_AW-bit address), axi_aclk/axi_aresetn.
module axi_lite_rr_arbiter #(
  parameter int              NM        = 2,
  parameter int              S_AW      = 32,
  parameter int              M_AW      = 7,
  parameter int              DW        = 32,
  parameter logic [S_AW-1:0] BASE_ADDR = 32'h40000000
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  // requester side
  input  logic [NM*S_AW-1:0]   s_awaddr,
  input  logic [NM*3-1:0]      s_awprot,
  input  logic [NM-1:0]        s_awvalid,
  output logic [NM-1:0]        s_awready,
  input  logic [NM*DW-1:0]     s_wdata,
  input  logic [NM*DW/8-1:0]   s_wstrb,
  input  logic [NM-1:0]        s_wvalid,
  output logic [NM-1:0]        s_wready,
  output logic [NM*2-1:0]      s_bresp,
  output logic [NM-1:0]        s_bvalid,
  input  logic [NM-1:0]        s_bready,
  input  logic [NM*S_AW-1:0]   s_araddr,
  input  logic [NM*3-1:0]      s_arprot,
  input  logic [NM-1:0]        s_arvalid,
  output logic [NM-1:0]        s_arready,
  output logic [NM*DW-1:0]     s_rdata,
  output logic [NM*2-1:0]      s_rresp,
  output logic [NM-1:0]        s_rvalid,
  input  logic [NM-1:0]        s_rready,
  // register-file side
  output logic [M_AW-1:0]      m_awaddr,
  output logic [2:0]           m_awprot,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [DW-1:0]        m_wdata,
  output logic [DW/8-1:0]      m_wstrb,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  output logic [M_AW-1:0]      m_araddr,
  output logic [2:0]           m_arprot,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [DW-1:0]        m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rvalid,
  output logic                 m_rready
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {IDLE, W_FWD, W_RESP, R_FWD, R_RESP, W_ERR, R_ERR} state_t;

  state_t          state;
  logic [GW-1:0]   rr;
  logic [GW-1:0]   g;
  logic [M_AW-1:0] addr_q;
  logic [2:0]      prot_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            aw_done;
  logic            w_done;

  logic [NM-1:0]   wr_req;
  logic [NM-1:0]   req;
  logic            sel_vld;
  logic [GW-1:0]   sel;
  logic            sel_wr;
  logic [S_AW-1:0] sel_addr;
  logic [2:0]      sel_prot;
  logic            in_win;
  logic            aw_hs;
  logic            w_hs;
  logic [GW-1:0]   rr_next;

  // A write needs both AW and W presented together; a write beats a read from the same requester.
  assign wr_req = s_awvalid & s_wvalid;
  assign req    = wr_req | s_arvalid;

  // Rotating priority search starting at rr.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int k = 0; k < NM; k++) begin
      int idx;
      idx = (int'(rr) + k) % NM;
      if (!sel_vld && req[idx]) begin
        sel_vld = 1'b1;
        sel     = GW'(idx);
      end
    end
  end

  always_comb begin
    sel_wr   = wr_req[sel];
    sel_addr = sel_wr ? s_awaddr[int'(sel)*S_AW +: S_AW] : s_araddr[int'(sel)*S_AW +: S_AW];
    sel_prot = sel_wr ? s_awprot[int'(sel)*3 +: 3] : s_arprot[int'(sel)*3 +: 3];
  end

  assign in_win  = (sel_addr[S_AW-1:M_AW] == BASE_ADDR[S_AW-1:M_AW]);
  assign aw_hs   = m_awvalid & m_awready;
  assign w_hs    = m_wvalid & m_wready;
  assign rr_next = (int'(g) == NM - 1) ? '0 : g + 1'b1;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state   <= IDLE;
      rr      <= '0;
      g       <= '0;
      addr_q  <= '0;
      prot_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            g      <= sel;
            addr_q <= sel_addr[M_AW-1:0];
            prot_q <= sel_prot;
            if (sel_wr) begin
              wdata_q <= s_wdata[int'(sel)*DW +: DW];
              wstrb_q <= s_wstrb[int'(sel)*SW +: SW];
              state   <= in_win ? W_FWD : W_ERR;
            end else begin
              state   <= in_win ? R_FWD : R_ERR;
            end
          end
        end
        W_FWD: begin
          // AW and W complete independently; leave once both have been accepted.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= W_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        W_RESP: begin
          if (m_bvalid && m_bready) begin
            state <= IDLE;
            rr    <= rr_next;
          end
        end
        R_FWD: begin
          if (m_arready) state <= R_RESP;
        end
        R_RESP: begin
          if (m_rvalid && m_rready) begin
            state <= IDLE;
            rr    <= rr_next;
          end
        end
        W_ERR: begin
          if (s_bready[g]) begin
            state <= IDLE;
            rr    <= rr_next;
          end
        end
        R_ERR: begin
          if (s_rready[g]) begin
            state <= IDLE;
            rr    <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Master side: valids decode from registered state/flags, payloads are the captured request.
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_awprot  = prot_q;
  assign m_arprot  = prot_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_awvalid = (state == W_FWD) && !aw_done;
  assign m_wvalid  = (state == W_FWD) && !w_done;
  assign m_arvalid = (state == R_FWD);
  assign m_bready  = (state == W_RESP) && s_bready[g];
  assign m_rready  = (state == R_RESP) && s_rready[g];

  // Requester side: only the granted index ever sees a nonzero ready/valid/payload.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_arready = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    s_rvalid  = '0;
    s_rresp   = '0;
    s_rdata   = '0;
    case (state)
      IDLE: begin
        // Gated by reset so a pending request cannot raise a ready while reset is held.
        if (axi_aresetn && sel_vld) begin
          if (sel_wr) begin
            s_awready[sel] = 1'b1;
            s_wready[sel]  = 1'b1;
          end else begin
            s_arready[sel] = 1'b1;
          end
        end
      end
      W_RESP: begin
        s_bvalid[g]               = m_bvalid;
        s_bresp[int'(g)*2 +: 2]   = m_bresp;
      end
      R_RESP: begin
        s_rvalid[g]               = m_rvalid;
        s_rresp[int'(g)*2 +: 2]   = m_rresp;
        s_rdata[int'(g)*DW +: DW] = m_rdata;
      end
      W_ERR: begin
        s_bvalid[g]               = 1'b1;
        s_bresp[int'(g)*2 +: 2]   = 2'b11;
      end
      R_ERR: begin
        s_rvalid[g]               = 1'b1;
        s_rresp[int'(g)*2 +: 2]   = 2'b11;
      end
      default: ;
    endcase
  end

endmodule
